// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer
//   Streams whole frames from a pixel generator to a 96x64 SSD1331 OLED over
//   its write-only SPI port (mode 3, MSB first). Each frame is a CS-low lead-in,
//   a 6-byte column/row window command, then WIDTH*HEIGHT RGB565 words, followed
//   by a CS-high gap. Frames repeat back-to-back while enable is high.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high
//   enable       level; sampled in IDLE and at the end of the gap
//   pixel_data   RGB565 value for the current pixel_index
//   pixel_index  row-major pixel index (y*WIDTH + x)
//   oled_cs      chip select, active low
//   oled_sclk    SPI clock, idles high
//   oled_sdin    serial data
//   oled_dc      0 = command byte, 1 = pixel data
//   frame_done   one-cycle pulse on the first gap cycle
//   busy         high whenever the FSM is not in IDLE
module oled_frame_streamer #(
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64,
  parameter int CLK_DIV = 4,
  parameter int GAP     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        oled_cs,
  output logic        oled_sclk,
  output logic        oled_sdin,
  output logic        oled_dc,
  output logic        frame_done,
  output logic        busy
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(GAP) + 1;

  localparam logic [DW-1:0] HALF     = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] SLOT_END = DW'(2 * CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP - 1);
  localparam logic [12:0]   LAST_PIX = 13'(WIDTH * HEIGHT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_PIX  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  // Window setup: column range 0..WIDTH-1, row range 0..HEIGHT-1.
  function automatic logic [7:0] cmd_byte(input logic [2:0] n);
    case (n)
      3'd0:    cmd_byte = 8'h15;
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = 8'(WIDTH - 1);
      3'd3:    cmd_byte = 8'h75;
      3'd4:    cmd_byte = 8'h00;
      default: cmd_byte = 8'(HEIGHT - 1);
    endcase
  endfunction

  logic [2:0]    state;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [2:0]    byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   shreg;
  logic          idx_inc;

  logic [2:0]    cmd_sel;
  logic [7:0]    cmd_nxt;
  logic [3:0]    last_bit;

  // Byte to launch at the next byte boundary: the first command when leaving
  // LEAD, otherwise the one after the byte currently shifting.
  always_comb begin
    cmd_sel  = (state == S_LEAD) ? 3'd0 : byte_cnt + 3'd1;
    cmd_nxt  = cmd_byte(cmd_sel);
    last_bit = (state == S_PIX) ? 4'd15 : 4'd7;
  end

  // Outputs are registered alongside the state, so every transition below
  // sets the pin values for the first cycle of the state it enters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      shreg       <= '0;
      idx_inc     <= 1'b0;
      pixel_index <= '0;
      oled_cs     <= 1'b1;
      oled_sclk   <= 1'b1;
      oled_sdin   <= 1'b0;
      oled_dc     <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      idx_inc    <= 1'b0;

      // Index advances the cycle after a pixel load, giving the generator a
      // full word time to present the next value.
      if (idx_inc)
        pixel_index <= (pixel_index == LAST_PIX) ? '0 : pixel_index + 13'd1;

      case (state)
        S_IDLE: begin
          if (enable) begin
            state   <= S_LEAD;
            oled_cs <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
          end
        end

        S_LEAD: begin
          if (div_cnt == HALF) begin
            state     <= S_CMD;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shreg     <= {cmd_nxt, 8'h00};
            oled_sdin <= cmd_nxt[7];
            oled_sclk <= 1'b0;
            oled_dc   <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_CMD, S_PIX: begin
          if (div_cnt == HALF)
            oled_sclk <= 1'b1;
          if (div_cnt != SLOT_END) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (bit_cnt != last_bit) begin
              bit_cnt   <= bit_cnt + 4'd1;
              shreg     <= shreg << 1;
              oled_sdin <= shreg[14];
              oled_sclk <= 1'b0;
            end else begin
              bit_cnt <= '0;
              if (state == S_CMD && byte_cnt != 3'd5) begin
                byte_cnt  <= byte_cnt + 3'd1;
                shreg     <= {cmd_nxt, 8'h00};
                oled_sdin <= cmd_nxt[7];
                oled_sclk <= 1'b0;
              end else if (state == S_CMD || pixel_index != '0) begin
                // pixel_index has already moved past the word just sent; it
                // is back at 0 only after the last pixel of the frame.
                state     <= S_PIX;
                shreg     <= pixel_data;
                oled_sdin <= pixel_data[15];
                oled_sclk <= 1'b0;
                oled_dc   <= 1'b1;
                idx_inc   <= 1'b1;
              end else begin
                state      <= S_GAP;
                gap_cnt    <= '0;
                oled_cs    <= 1'b1;
                oled_sdin  <= 1'b0;
                oled_dc    <= 1'b0;
                frame_done <= 1'b1;
              end
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_END) begin
            if (enable) begin
              state   <= S_LEAD;
              oled_cs <= 1'b0;
              div_cnt <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Bench for oled_frame_streamer on a small 4x2 panel with CLK_DIV=2, GAP=5.
// A negedge SPI monitor decodes bytes/words and checks SCLK/SDIN/DC timing;
// the initial block drives directed steps with randomized pixel content and
// reset points, and compares decoded traffic against values computed from the
// frame format.
module tb_oled_frame_streamer;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int CD = 2;
  localparam int GP = 5;
  localparam int N  = W * H;
  localparam int FL = CD + (48 + 16 * N) * 2 * CD;

  logic        clock = 1'b0;
  logic        reset, enable;
  logic [15:0] pixel_data;
  logic [12:0] pixel_index;
  logic        oled_cs, oled_sclk, oled_sdin, oled_dc, frame_done, busy;

  always #5 clock = ~clock;

  oled_frame_streamer #(.WIDTH(W), .HEIGHT(H), .CLK_DIV(CD), .GAP(GP)) dut (
    .clock(clock), .reset(reset), .enable(enable), .pixel_data(pixel_data),
    .pixel_index(pixel_index), .oled_cs(oled_cs), .oled_sclk(oled_sclk),
    .oled_sdin(oled_sdin), .oled_dc(oled_dc), .frame_done(frame_done), .busy(busy)
  );

  int vec  = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel generator: two-stage registered source, value = index*0x0101 ^ salt.
  logic        gen_const = 1'b0;
  logic [15:0] const_val = 16'h0000;
  logic [15:0] salt = 16'h0000;
  logic [15:0] g1 = 16'h0000, g2 = 16'h0000;

  function automatic logic [15:0] f(input int i);
    logic [15:0] v;
    v = 16'(i * 32'h0101);
    return v ^ salt;
  endfunction

  always @(posedge clock) begin
    g1 <= f(int'(pixel_index));
    g2 <= g1;
  end
  assign pixel_data = gen_const ? const_val : g2;

  // SPI monitor
  logic [7:0]  got_cmd[$];
  logic [15:0] got_pix[$];
  logic        psclk = 1'b1, pcs = 1'b1, psdin = 1'b0, pdcw = 1'b0, prst = 1'b1, wdc = 1'b0;
  int          run = 0, nb = 0, fd_cnt = 0;
  logic [15:0] sh = 16'h0;
  logic [12:0] idx0 = 13'h0;

  always @(negedge clock) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (!prst) begin
      if (oled_cs === 1'b1) check("sclk_idle_high", oled_sclk, 1);
      if (!pcs && oled_cs === 1'b0) begin
        if (oled_sclk !== psclk) check("sclk_phase", run, CD);
        if (oled_sdin !== psdin) check("sdin_edge", {psclk, oled_sclk}, 2'b10);
        if (oled_dc !== pdcw)    check("dc_edge", {psclk, oled_sclk}, 2'b10);
      end
      if (!pcs && oled_cs === 1'b1) check("last_high", run, CD);
    end
    if (pcs && oled_cs === 1'b0) run = 1;
    else if (oled_sclk !== psclk) run = 1;
    else run++;

    if (oled_cs !== 1'b0) nb = 0;
    else if (!pcs && psclk === 1'b0 && oled_sclk === 1'b1) begin
      if (nb == 0) begin
        wdc  = oled_dc;
        idx0 = pixel_index;
      end else check("dc_hold", oled_dc, wdc);
      sh = {sh[14:0], oled_sdin};
      nb++;
      if (!wdc && nb == 8) begin
        got_cmd.push_back(sh[7:0]);
        nb = 0;
      end else if (wdc && nb == 16) begin
        check("idx_stable", pixel_index, idx0);
        check("idx_next", idx0, (got_pix.size() % N + 1) % N);
        got_pix.push_back(sh);
        nb = 0;
      end
    end
    psclk = oled_sclk; pcs = oled_cs; psdin = oled_sdin; pdcw = oled_dc; prst = reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_cs"},   oled_cs, 1);
    check({tag, "_sclk"}, oled_sclk, 1);
    check({tag, "_sdin"}, oled_sdin, 0);
    check({tag, "_dc"},   oled_dc, 0);
    check({tag, "_idx"},  pixel_index, 0);
    check({tag, "_fd"},   frame_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin tick(1); n++; end while (frame_done !== 1'b1 && n < FL + GP + 50);
    check("fd_timeout", frame_done, 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin tick(1); n++; end while (busy !== 1'b0 && n < 2 * (FL + GP) + 50);
    check("idle_timeout", busy, 0);
  endtask

  task automatic chk_frames(input string tag, input int nf);
    logic [7:0] e[6];
    e[0] = 8'h15; e[1] = 8'h00; e[2] = 8'(W - 1);
    e[3] = 8'h75; e[4] = 8'h00; e[5] = 8'(H - 1);
    check({tag, "_ncmd"}, got_cmd.size(), 6 * nf);
    check({tag, "_npix"}, got_pix.size(), N * nf);
    foreach (got_cmd[i]) check({tag, "_cmd"}, got_cmd[i], e[i % 6]);
    foreach (got_pix[i]) check({tag, "_pix"}, got_pix[i], gen_const ? const_val : f(i % N));
  endtask

  task automatic clear_mon();
    got_cmd.delete();
    got_pix.delete();
    fd_cnt = 0;
  endtask

  task automatic pulse_frame(input string tag);
    int n;
    clear_mon();
    salt = 16'($urandom);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    wait_idle(n);
    tick(3);
    chk_frames(tag, 1);
    check({tag, "_fd_once"}, fd_cnt, 1);
  endtask

  initial begin
    int n, p, c;
    reset = 1'b1;
    enable = 1'b0;
    tick(3);
    chk_reset("rst");
    reset = 1'b0;
    tick(2);
    chk_reset("idle");

    // Single frame, enable pulsed one cycle.
    clear_mon();
    salt = 16'($urandom);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    check("busy_rise", busy, 1);
    check("cs_fall", oled_cs, 0);
    wait_fd(n);
    check("frame_len", n, FL);
    check("fd_cs_high", oled_cs, 1);
    wait_idle(n);
    check("gap_len", n, GP);
    tick(10);
    check("stays_idle", busy, 0);
    check("idle_cs", oled_cs, 1);
    chk_frames("single", 1);
    check("single_fd_once", fd_cnt, 1);

    // Back-to-back frames, constant pixel value.
    clear_mon();
    gen_const = 1'b1;
    const_val = 16'hFB2C;
    enable = 1'b1;
    wait_fd(n);
    wait_fd(p);
    check("fd_period", p, FL + GP);
    c = 0;
    while (oled_cs === 1'b1 && c < GP + 20) begin c++; tick(1); end
    check("cs_gap_run", c, GP);
    wait_fd(p);
    check("fd_period2", c + p, FL + GP);
    enable = 1'b0;
    wait_idle(n);
    check("b2b_gap_len", n, GP);
    chk_frames("b2b", 3);
    check("b2b_fd_cnt", fd_cnt, 3);
    gen_const = 1'b0;

    // Enable dropped halfway through the pixel phase.
    clear_mon();
    salt = 16'($urandom);
    enable = 1'b1;
    n = 0;
    while (got_pix.size() < N / 2 && n < FL + 50) begin tick(1); n++; end
    check("half_reached", got_pix.size() >= N / 2, 1);
    enable = 1'b0;
    wait_idle(n);
    tick(2);
    chk_frames("drop", 1);
    check("drop_fd_once", fd_cnt, 1);
    check("drop_cs", oled_cs, 1);

    // Reset mid-CMD, then a fresh frame.
    clear_mon();
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    tick(CD + $urandom_range(1, 46 * 2 * CD));
    reset = 1'b1;
    tick(1);
    chk_reset("rst_cmd");
    reset = 1'b0;
    tick(2);
    pulse_frame("after_cmd_rst");

    // Reset mid-PIX, then a fresh frame.
    clear_mon();
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    tick(CD + 48 * 2 * CD + $urandom_range(1, 16 * N * 2 * CD - 4));
    reset = 1'b1;
    tick(1);
    chk_reset("rst_pix");
    reset = 1'b0;
    tick(2);
    pulse_frame("after_pix_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
